// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: state encoding, block geometry
// and the word-address helper used by the fill sequencer.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_D_FILL = 2'd1,
        ST_I_FILL = 2'd2,
        ST_STORE  = 2'd3
    } arb_state_e;

    // Address/data width of the shared memory and both caches.
    localparam int ADDR_W = 16;

    // 16-bit words per cache block; the counters need one extra bit so they
    // can express "all words done".
    localparam int BLOCK_WORDS = 8;
    localparam int CNT_W       = $clog2(BLOCK_WORDS) + 1;

    // Clears the in-block byte offset (8 words x 2 bytes).
    localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hFFF0;

    // Byte address of word idx inside the block starting at base.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-2:0]  idx);
        return base | {{(ADDR_W-CNT_W){1'b0}}, idx, 1'b0};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus between the arbiter and the shared data memory. The arbiter is the
// master (drives requests); the memory is the slave (returns read data).
interface mem_arbiter_if #(parameter int ADDR_W = 16);

    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_rdata;
    logic              mem_data_valid;

    modport master (
        output mem_enable, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_data_valid
    );

    modport slave (
        input  mem_enable, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_data_valid
    );

endinterface

// File: rtl/mem_fill_seq.sv
// Block-fill sequencer: one counter paces the word reads sent to memory,
// a second counts returning words. Both sit at zero whenever no fill is
// active, so every fill starts at word 0 without an explicit start pulse.
module mem_fill_seq
    import mem_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_active,
    input  logic                   i_valid,
    input  logic [ADDR_W-1:0]      i_base,
    output logic                   o_issue,
    output logic [ADDR_W-1:0]      o_issue_addr,
    output logic [ADDR_W-1:0]      o_rx_addr,
    output logic [BLOCK_WORDS-1:0] o_word_en,
    output logic                   o_last
);

    logic [CNT_W-1:0] r_issue_cnt;
    logic [CNT_W-1:0] r_rx_cnt;
    logic             w_rx_room;

    assign o_issue   = (r_issue_cnt < CNT_W'(BLOCK_WORDS));
    assign w_rx_room = (r_rx_cnt < CNT_W'(BLOCK_WORDS));
    assign o_last    = (r_rx_cnt == CNT_W'(BLOCK_WORDS - 1));

    assign o_issue_addr = word_addr(i_base, r_issue_cnt[CNT_W-2:0]);
    assign o_rx_addr    = word_addr(i_base, r_rx_cnt[CNT_W-2:0]);

    // One-hot enable selecting the word slot currently being received.
    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_word_en
            assign o_word_en[gi] = (r_rx_cnt == CNT_W'(gi));
        end
    endgenerate

    // Advance issue count once per cycle and receive count once per valid word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_cnt <= '0;
            r_rx_cnt    <= '0;
        end else if (!i_active) begin
            r_issue_cnt <= '0;
            r_rx_cnt    <= '0;
        end else begin
            if (o_issue)
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            if (i_valid && w_rx_room)
                r_rx_cnt <= r_rx_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shared data-memory arbiter for the I-cache and D-cache. Grants one
// transaction at a time (D miss > D store > I miss), runs 8-word block
// fills through mem_fill_seq, performs single-cycle write-through stores,
// and raises the IF/MEM stalls while a request is outstanding.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_miss,
    input  logic [ADDR_W-1:0]      i_miss_addr,
    input  logic                   d_miss,
    input  logic [ADDR_W-1:0]      d_miss_addr,
    input  logic                   d_store,
    input  logic [ADDR_W-1:0]      d_store_addr,
    input  logic [ADDR_W-1:0]      d_store_data,
    mem_arbiter_if.master          mem,
    output logic [ADDR_W-1:0]      fill_addr,
    output logic [ADDR_W-1:0]      fill_data,
    output logic [BLOCK_WORDS-1:0] fill_word_en,
    output logic                   i_fill_we,
    output logic                   d_fill_we,
    output logic                   i_tag_we,
    output logic                   d_tag_we,
    output logic                   i_stall,
    output logic                   d_stall,
    output logic                   busy
);

    arb_state_e r_state;
    arb_state_e w_state_next;

    // Block base for fills, or the store address; store data alongside.
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_wdata;

    logic                   w_in_fill;
    logic                   w_issue;
    logic [ADDR_W-1:0]      w_issue_addr;
    logic [ADDR_W-1:0]      w_rx_addr;
    logic [BLOCK_WORDS-1:0] w_word_en;
    logic                   w_last;

    assign w_in_fill = (r_state == ST_D_FILL) || (r_state == ST_I_FILL);

    mem_fill_seq u_fill_seq (
        .clk          (clk),
        .rst          (rst),
        .i_active     (w_in_fill),
        .i_valid      (mem.mem_data_valid),
        .i_base       (r_addr),
        .o_issue      (w_issue),
        .o_issue_addr (w_issue_addr),
        .o_rx_addr    (w_rx_addr),
        .o_word_en    (w_word_en),
        .o_last       (w_last)
    );

    // State register; reset abandons any fill in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Capture the granted request; inputs are only looked at while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == ST_IDLE) begin
            if (d_miss) begin
                r_addr <= d_miss_addr & BLOCK_MASK;
            end else if (d_store) begin
                r_addr  <= d_store_addr;
                r_wdata <= d_store_data;
            end else if (i_miss) begin
                r_addr <= i_miss_addr & BLOCK_MASK;
            end
        end
    end

    // Arbitration, fill/store sequencing and stall generation.
    always_comb begin
        w_state_next   = r_state;
        mem.mem_enable = 1'b0;
        mem.mem_wr     = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_wdata  = '0;
        fill_addr      = '0;
        fill_data      = '0;
        fill_word_en   = '0;
        i_fill_we      = 1'b0;
        d_fill_we      = 1'b0;
        i_tag_we       = 1'b0;
        d_tag_we       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (d_miss)
                    w_state_next = ST_D_FILL;
                else if (d_store)
                    w_state_next = ST_STORE;
                else if (i_miss)
                    w_state_next = ST_I_FILL;
            end
            ST_D_FILL, ST_I_FILL: begin
                mem.mem_enable = w_issue;
                if (w_issue)
                    mem.mem_addr = w_issue_addr;
                // Progress is driven purely by returning words, so memory
                // latency never enters the FSM.
                if (mem.mem_data_valid) begin
                    fill_data    = mem.mem_rdata;
                    fill_addr    = w_rx_addr;
                    fill_word_en = w_word_en;
                    if (r_state == ST_D_FILL) begin
                        d_fill_we = 1'b1;
                        d_tag_we  = w_last;
                    end else begin
                        i_fill_we = 1'b1;
                        i_tag_we  = w_last;
                    end
                    if (w_last)
                        w_state_next = ST_IDLE;
                end
            end
            ST_STORE: begin
                mem.mem_enable = 1'b1;
                mem.mem_wr     = 1'b1;
                mem.mem_addr   = r_addr;
                mem.mem_wdata  = r_wdata;
                w_state_next   = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // A miss stalls until the cache sees a hit (the cycle after the tag
        // write); a store is finished in its STORE cycle.
        i_stall = i_miss | (r_state == ST_I_FILL);
        d_stall = d_miss | (d_store & (r_state != ST_STORE)) | (r_state == ST_D_FILL);
        busy    = (r_state != ST_IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. A fixed 4-cycle memory answers reads; a
// transaction-level scheduler predicts every output per cycle from the
// grant rules and fill timeline, and literal checks pin key cycles.
module tb_mem_arbiter;

    localparam int NC = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_store = 1'b0;
    logic [15:0] i_miss_addr = '0, d_miss_addr = '0;
    logic [15:0] d_store_addr = '0, d_store_data = '0;
    logic [15:0] fill_addr, fill_data;
    logic [7:0]  fill_word_en;
    logic        i_fill_we, d_fill_we, i_tag_we, d_tag_we;
    logic        i_stall, d_stall, busy;

    bit chk_en = 1'b0;
    bit stray  = 1'b0;
    int cyc    = 0;
    int tests  = 0;
    int fails  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if mif ();

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_miss       (i_miss),
        .i_miss_addr  (i_miss_addr),
        .d_miss       (d_miss),
        .d_miss_addr  (d_miss_addr),
        .d_store      (d_store),
        .d_store_addr (d_store_addr),
        .d_store_data (d_store_data),
        .mem          (mif.master),
        .fill_addr    (fill_addr),
        .fill_data    (fill_data),
        .fill_word_en (fill_word_en),
        .i_fill_we    (i_fill_we),
        .d_fill_we    (d_fill_we),
        .i_tag_we     (i_tag_we),
        .d_tag_we     (d_tag_we),
        .i_stall      (i_stall),
        .d_stall      (d_stall),
        .busy         (busy)
    );

    // Memory: a read issued in cycle c returns ~addr in cycle c+4.
    logic [16:0] pipe [0:3];
    always @(posedge clk) begin
        if (!chk_en) begin
            for (int i = 0; i < 4; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {mif.mem_enable & ~mif.mem_wr, mif.mem_addr};
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mif.mem_data_valid = pipe[3][16] | stray;
    assign mif.mem_rdata      = stray ? 16'hDEAD : (pipe[3][16] ? ~pipe[3][15:0] : 16'h0000);

    typedef struct packed {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] faddr;
        logic [15:0] fdata;
        logic [7:0]  wen;
        logic        ifwe;
        logic        dfwe;
        logic        itag;
        logic        dtag;
        logic        istall;
        logic        dstall;
        logic        busy;
    } obs_t;

    obs_t       sched [0:NC-1];
    logic [1:0] kind  [0:NC-1];   // 0 idle, 1 D fill, 2 I fill, 3 store
    obs_t       act   [0:NC-1];
    int         free_at = 0;

    // A fill granted in cycle g: reads g+1..g+8, words back g+5..g+12,
    // tag written with the last word, arbiter free again at g+13.
    task automatic put_fill(input int g, input logic [15:0] base, input bit is_d);
        for (int k = 0; k < 8; k++) begin
            logic [15:0] wa;
            wa = base + 16'(2 * k);
            sched[g+1+k].en    = 1'b1;
            sched[g+1+k].addr  = wa;
            sched[g+5+k].faddr = wa;
            sched[g+5+k].fdata = ~wa;
            sched[g+5+k].wen   = 8'(1 << k);
            if (is_d) sched[g+5+k].dfwe = 1'b1;
            else      sched[g+5+k].ifwe = 1'b1;
        end
        if (is_d) sched[g+12].dtag = 1'b1;
        else      sched[g+12].itag = 1'b1;
        for (int c = g + 1; c <= g + 12; c++) begin
            kind[c]       = is_d ? 2'd1 : 2'd2;
            sched[c].busy = 1'b1;
        end
        free_at = g + 13;
    endtask

    task automatic put_store(input int g, input logic [15:0] a, input logic [15:0] d);
        sched[g+1].en    = 1'b1;
        sched[g+1].wr    = 1'b1;
        sched[g+1].addr  = a;
        sched[g+1].wdata = d;
        sched[g+1].busy  = 1'b1;
        kind[g+1]        = 2'd3;
        free_at          = g + 2;
    endtask

    // Per-cycle model update and comparison of every output.
    always @(negedge clk) begin
        obs_t o;
        obs_t e;
        if (chk_en && cyc + 14 < NC) begin
            if (!rst) begin
                for (int c = cyc; c < NC; c++) begin
                    sched[c] = '0;
                    kind[c]  = 2'd0;
                end
                free_at = cyc;
            end else if (cyc >= free_at) begin
                if (d_miss)       put_fill(cyc, d_miss_addr & 16'hFFF0, 1'b1);
                else if (d_store) put_store(cyc, d_store_addr, d_store_data);
                else if (i_miss)  put_fill(cyc, i_miss_addr & 16'hFFF0, 1'b0);
            end
            e        = sched[cyc];
            e.istall = i_miss | (kind[cyc] == 2'd2);
            e.dstall = d_miss | (d_store & (kind[cyc] != 2'd3)) | (kind[cyc] == 2'd1);
            o.en     = mif.mem_enable;
            o.wr     = mif.mem_wr;
            o.addr   = mif.mem_addr;
            o.wdata  = mif.mem_wdata;
            o.faddr  = fill_addr;
            o.fdata  = fill_data;
            o.wen    = fill_word_en;
            o.ifwe   = i_fill_we;
            o.dfwe   = d_fill_we;
            o.itag   = i_tag_we;
            o.dtag   = d_tag_we;
            o.istall = i_stall;
            o.dstall = d_stall;
            o.busy   = busy;
            act[cyc] = o;
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL cycle %0d outputs: got %h expected %h", cyc, o, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Act as the cache: wait (bounded) for the completing event, then move
    // to the following cycle where the request may be withdrawn.
    task automatic wait_evt(input int which, input string nm);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            case (which)
                0:       seen = (i_tag_we === 1'b1);
                1:       seen = (d_tag_we === 1'b1);
                default: seen = (mif.mem_enable === 1'b1) && (mif.mem_wr === 1'b1);
            endcase
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: event seen 0 expected 1 within 60 cycles", nm);
        end
        tick();
    endtask

    initial begin
        int t0, t1, rc;
        #2 rst = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rc = cyc;
        tick();
        rst = 1'b1;
        tick();
        chk("reset_outputs_zero", 16'(act[rc] == '0), 16'd1);
        $display("[TB] reset checked at cycle %0d", rc);

        // I-cache miss at 0x1234
        t0 = cyc;
        i_miss = 1'b1; i_miss_addr = 16'h1234;
        wait_evt(0, "i_tag_1234");
        i_miss = 1'b0;
        tick(); tick();
        chk("i1_first_issue", act[t0+1].addr, 16'h1230);
        chk("i1_first_en", 16'(act[t0+1].en), 16'd1);
        chk("i1_last_issue", act[t0+8].addr, 16'h123E);
        chk("i1_issue_done", 16'(act[t0+9].en), 16'd0);
        chk("i1_wen_first", 16'(act[t0+5].wen), 16'h0001);
        chk("i1_fdata_first", act[t0+5].fdata, 16'hEDCF);
        chk("i1_wen_last", 16'(act[t0+12].wen), 16'h0080);
        chk("i1_faddr_last", act[t0+12].faddr, 16'h123E);
        chk("i1_tag_c12", 16'(act[t0+12].itag), 16'd1);
        chk("i1_stall_c12", 16'(act[t0+12].istall), 16'd1);
        chk("i1_stall_c13", 16'(act[t0+13].istall), 16'd0);
        $display("[TB] I-fill 0x1234 granted cycle %0d", t0);

        // Simultaneous I miss 0x0040 and D miss 0x8000
        t0 = cyc;
        i_miss = 1'b1; i_miss_addr = 16'h0040;
        d_miss = 1'b1; d_miss_addr = 16'h8000;
        wait_evt(1, "d_tag_8000");
        d_miss = 1'b0;
        wait_evt(0, "i_tag_0040");
        i_miss = 1'b0;
        tick(); tick();
        chk("dual_d_first", act[t0+1].addr, 16'h8000);
        chk("dual_d_tag", 16'(act[t0+12].dtag), 16'd1);
        chk("dual_gap_busy", 16'(act[t0+13].busy), 16'd0);
        chk("dual_gap_dstall", 16'(act[t0+13].dstall), 16'd0);
        chk("dual_gap_istall", 16'(act[t0+13].istall), 16'd1);
        chk("dual_i_first", act[t0+14].addr, 16'h0040);
        chk("dual_i_tag", 16'(act[t0+25].itag), 16'd1);
        $display("[TB] D-fill 0x8000 then I-fill 0x0040 from cycle %0d", t0);

        // Plain write-through store
        t0 = cyc;
        d_store = 1'b1; d_store_addr = 16'h2222; d_store_data = 16'hBEEF;
        wait_evt(2, "store_2222");
        d_store = 1'b0;
        tick();
        chk("st_stall_req", 16'(act[t0].dstall), 16'd1);
        chk("st_en_wr", 16'({act[t0+1].en, act[t0+1].wr}), 16'd3);
        chk("st_addr", act[t0+1].addr, 16'h2222);
        chk("st_wdata", act[t0+1].wdata, 16'hBEEF);
        chk("st_stall_drop", 16'(act[t0+1].dstall), 16'd0);
        $display("[TB] store 0x2222<=0xBEEF granted cycle %0d", t0);

        // Store to a missing block: fill first, then the store
        t0 = cyc;
        d_miss = 1'b1; d_miss_addr = 16'h3006;
        d_store = 1'b1; d_store_addr = 16'h3006; d_store_data = 16'h1357;
        wait_evt(1, "d_tag_3000");
        d_miss = 1'b0;
        wait_evt(2, "store_3006");
        d_store = 1'b0;
        tick();
        chk("ms_first", act[t0+1].addr, 16'h3000);
        chk("ms_last", act[t0+8].addr, 16'h300E);
        chk("ms_gap_en", 16'(act[t0+13].en), 16'd0);
        chk("ms_gap_dstall", 16'(act[t0+13].dstall), 16'd1);
        chk("ms_store_addr", act[t0+14].addr, 16'h3006);
        chk("ms_store_wr", 16'(act[t0+14].wr), 16'd1);
        chk("ms_store_wdata", act[t0+14].wdata, 16'h1357);
        $display("[TB] D-fill 0x3000 then store 0x3006 from cycle %0d", t0);

        // Reset in the middle of a fill, late words, then a fresh fill
        t0 = cyc;
        i_miss = 1'b1; i_miss_addr = 16'h5678;
        repeat (6) tick();
        rst = 1'b0; i_miss = 1'b0;
        rc = cyc;
        tick(); tick();
        rst = 1'b1;
        repeat (4) tick();
        t1 = cyc;
        i_miss = 1'b1;
        wait_evt(0, "i_tag_5670");
        i_miss = 1'b0;
        tick(); tick();
        chk("rs_pre_issue", 16'(act[t0+5].en), 16'd1);
        chk("rs_zero", 16'(act[rc] == '0), 16'd1);
        chk("rs_late_we8", 16'({act[t0+8].ifwe, act[t0+8].itag}), 16'd0);
        chk("rs_late_we9", 16'({act[t0+9].ifwe, act[t0+9].itag}), 16'd0);
        chk("rs_restart_addr", act[t1+1].addr, 16'h5670);
        chk("rs_restart_wen", 16'(act[t1+5].wen), 16'h0001);
        $display("[TB] reset at cycle %0d, refill 0x5670 granted cycle %0d", rc, t1);

        // Stray valid while idle
        rc = cyc;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        chk("stray_we", 16'({act[rc].ifwe, act[rc].dfwe, act[rc].itag, act[rc].dtag}), 16'd0);
        chk("stray_wen", 16'(act[rc].wen), 16'd0);
        $display("[TB] stray valid at cycle %0d", rc);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: finished 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single shared 4-cycle data memory behind the I-cache and D-cache.
- Arbitrates I-cache miss fills, D-cache miss fills and D-cache write-through stores; only one transaction is in flight at a time.
- Sequences the 8-word block fill: issues word reads, steers returning words into the selected cache/way, then writes the tag.
- Drives the pipeline stall signals for IF and MEM.

Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block (16 B block); counter width is log2(BLOCK_WORDS)+1.
- ADDR_W, 16, address/data width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- i_miss  in  1  I-cache miss request; held high until i_stall drops
- i_miss_addr  in  16  I-cache miss address
- d_miss  in  1  D-cache miss request; held high until d_stall drops
- d_miss_addr  in  16  D-cache miss address
- d_store  in  1  write-through store request
- d_store_addr  in  16  store address
- d_store_data  in  16  store data
- mem_enable  out  1  memory request strobe
- mem_wr  out  1  memory write (1) / read (0)
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_data_valid  in  1  mem_rdata valid this cycle
- fill_addr  out  16  address of the word being written into the cache
- fill_data  out  16  word being written (mem_rdata pass-through)
- fill_word_en  out  8  one-hot word enable for the fill
- i_fill_we  out  1  I-cache data-array write enable
- d_fill_we  out  1  D-cache data-array write enable
- i_tag_we  out  1  I-cache tag write enable
- d_tag_we  out  1  D-cache tag write enable
- i_stall  out  1  stall IF
- d_stall  out  1  stall MEM
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, counters=0, latched address/data=0, all outputs 0. Reset mid-fill abandons the fill. No tag write occurs. mem_data_valid arriving after reset is ignored.
- States: IDLE, D_FILL, I_FILL, STORE.
- Arbitration, sampled only in IDLE, fixed priority d_miss > d_store > i_miss.
  - IDLE->D_FILL on d_miss.
  - IDLE->STORE on d_store & ~d_miss.
  - IDLE->I_FILL on i_miss & ~d_miss & ~d_store.
- Grant latches the block base (addr & 16'hFFF0), or store addr/data. Later changes to the request inputs are ignored until the next IDLE.
- FILL, issue phase: issue_cnt runs 0..7, one read per cycle.
  - mem_enable=1, mem_wr=0, mem_addr=base|(issue_cnt<<1).
  - mem_enable=0 once issue_cnt reaches 8.
- FILL, receive phase, on each mem_data_valid:
  - fill_data=mem_rdata, fill_word_en=1<<rx_cnt, fill_addr=base|(rx_cnt<<1).
  - i_fill_we or d_fill_we = 1 (per state); rx_cnt++.
  - The FSM counts valids only and does not depend on memory latency.
- Last valid (rx_cnt==7): the data write plus i_tag_we/d_tag_we in the same cycle; next state IDLE.
- mem_data_valid seen in IDLE or STORE is ignored.
- STORE: one cycle with mem_enable=1, mem_wr=1, mem_addr/mem_wdata from the latch; then IDLE.
- Stalls (combinational):
  - i_stall = (i_miss & ~(state==IDLE & i_miss granted-never-in-same-cycle)) | state==I_FILL. In practice: high while i_miss is pending or I_FILL is active.
  - d_stall = d_miss | (d_store & state!=STORE) | state==D_FILL.
  - A store is complete in its STORE cycle, so d_stall drops there.
  - A miss stall drops the cycle after the tag write, when the cache re-reads as a hit.
- Store to a missing block: d_miss wins; fill first, then IDLE, then STORE.
- A request arriving during another transaction waits. It is granted on the first IDLE cycle in which it is the highest priority.
- Fill timing with 4-cycle memory, request at cycle 0:
  - Issues at cycles 1..8, valids at 5..12.
  - Tag write at cycle 12; IDLE and stall low at cycle 13.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, D_FILL=2'd1, I_FILL=2'd2, STORE=2'd3);
  - BLOCK_WORDS=8;
  - BLOCK_MASK=16'hFFF0.
- One sub-module, mem_fill_seq: issue_cnt/rx_cnt counters, address generation and the one-hot word enable.
- Arbitration FSM and stall logic stay in mem_arbiter.

Test Plan:
- Reset → all outputs 0. i_miss=1 addr 16'h1234 → issues 16'h1230..16'h123E in cycles 1..8; fill_word_en 01..80 on valids; i_tag_we at cycle 12; i_stall low at cycle 13.
- Simultaneous i_miss (16'h0040) and d_miss (16'h8000) → D fill first (addresses 16'h8000..), then IDLE, then I fill at 16'h0040. i_stall high throughout; d_stall drops after the D tag write.
- d_store addr 16'h2222 data 16'hBEEF, no miss → STORE next cycle with mem_enable=1, mem_wr=1, mem_addr=16'h2222, mem_wdata=16'hBEEF; d_stall low in that cycle.
- d_miss + d_store to 16'h3006 → full D fill of 16'h3000..16'h300E, then write of 16'h3006; no overlap of mem_enable between the two.
- rst=0 at cycle 6 of a fill → outputs 0 immediately. Late mem_data_valid pulses produce no fill_we/tag_we. A new i_miss after reset restarts at word 0.
- Stray mem_data_valid in IDLE → no write enables asserted.
